// File: rtl/click_event_gen.sv
// click_event_gen: debounces the raw mouse left button into single-cycle click/release
// events, with click coordinates captured (and clamped) at the start of each press.
module click_event_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 65000,
   parameter int unsigned X_MAX = 1023,
   parameter int unsigned Y_MAX = 767
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic        click,
   output logic [11:0] click_xpos,
   output logic [11:0] click_ypos,
   output logic        release_evt,
   output logic        left_stable
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
   localparam bit ONE = (DEBOUNCE_CYCLES == 1);
   typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
   logic r_sync1, r_sync2;
   logic [11:0] r_cap_x, r_cap_y, w_clamp_x, w_clamp_y;
   logic r_click, r_release, r_armed;
   logic [11:0] r_click_x, r_click_y;
   logic w_press_acc, w_rel_acc;
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_clamp_x = (mouse_xpos > 12'(X_MAX)) ? 12'(X_MAX) : mouse_xpos;
   assign w_clamp_y = (mouse_ypos > 12'(Y_MAX)) ? 12'(Y_MAX) : mouse_ypos;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_sync1 <= mouse_left;
         r_sync2 <= r_sync1;
      end
   end
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: if (r_sync2) begin
            w_next     = ONE ? PRESSED : PRESS_DB;
            w_cnt_next = ONE ? '0 : CW'(1);
         end
         PRESS_DB: begin
            w_next     = !r_sync2 ? IDLE : (w_cnt_inc == LAST) ? PRESSED : PRESS_DB;
            w_cnt_next = (w_next == PRESS_DB) ? w_cnt_inc : '0;
         end
         PRESSED: if (!r_sync2) begin
            w_next     = ONE ? IDLE : REL_DB;
            w_cnt_next = ONE ? '0 : CW'(1);
         end
         REL_DB: begin
            w_next     = r_sync2 ? PRESSED : (w_cnt_inc == LAST) ? IDLE : REL_DB;
            w_cnt_next = (w_next == REL_DB) ? w_cnt_inc : '0;
         end
         default: begin
            w_next     = IDLE;
            w_cnt_next = '0;
         end
      endcase
   end
   always_comb begin
      w_press_acc = (w_next == PRESSED) && (r_state == IDLE || r_state == PRESS_DB);
      w_rel_acc   = (w_next == IDLE) && (r_state == PRESSED || r_state == REL_DB);
      left_stable = (r_state == PRESSED) || (r_state == REL_DB);
   end
   // With single-cycle debounce the capture and acceptance share an edge, so take the live clamp.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cap_x   <= '0;
         r_cap_y   <= '0;
         r_click   <= 1'b0;
         r_release <= 1'b0;
         r_armed   <= 1'b0;
         r_click_x <= '0;
         r_click_y <= '0;
      end else begin
         if (r_state == IDLE && r_sync2) begin
            r_cap_x <= w_clamp_x;
            r_cap_y <= w_clamp_y;
         end
         r_click   <= w_press_acc && enable;
         r_release <= w_rel_acc && r_armed;
         if (w_press_acc && enable) begin
            r_click_x <= (r_state == IDLE) ? w_clamp_x : r_cap_x;
            r_click_y <= (r_state == IDLE) ? w_clamp_y : r_cap_y;
         end
         if (w_press_acc)
            r_armed <= enable;
         else if (w_rel_acc)
            r_armed <= 1'b0;
      end
   end
   assign click       = r_click;
   assign release_evt = r_release;
   assign click_xpos  = r_click_x;
   assign click_ypos  = r_click_y;
endmodule

// File: tb/tb_click_event_gen.sv
// tb_click_event_gen: directed checks of click_event_gen with 4-cycle and 1-cycle debounce.
module tb_click_event_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b1;
   logic ml4 = 1'b0, ml1 = 1'b0;
   logic [11:0] xpos = 12'd300, ypos = 12'd200;
   logic click4, rel4, ls4, click1, rel1, ls1;
   logic [11:0] cx4, cy4, cx1, cy1;
   int errors = 0, checks = 0;
   int n_click4 = 0, n_rel4 = 0, n_click1 = 0, n_rel1 = 0, n_both = 0;
   int base_c, base_r;
   always #5 clk = ~clk;
   click_event_gen #(.DEBOUNCE_CYCLES(4)) u4 (
      .clk(clk), .rst(rst), .enable(enable), .mouse_left(ml4),
      .mouse_xpos(xpos), .mouse_ypos(ypos), .click(click4),
      .click_xpos(cx4), .click_ypos(cy4), .release_evt(rel4), .left_stable(ls4));
   click_event_gen #(.DEBOUNCE_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .enable(enable), .mouse_left(ml1),
      .mouse_xpos(xpos), .mouse_ypos(ypos), .click(click1),
      .click_xpos(cx1), .click_ypos(cy1), .release_evt(rel1), .left_stable(ls1));
   always @(posedge clk) begin
      n_click4 <= n_click4 + int'(click4);
      n_rel4   <= n_rel4 + int'(rel4);
      n_click1 <= n_click1 + int'(click1);
      n_rel1   <= n_rel1 + int'(rel1);
      n_both   <= n_both + int'(click1 && rel1) + int'(click4 && rel4);
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   initial begin
      step(2);
      chk("rst_click", 32'(click4), 0);
      chk("rst_release", 32'(rel4), 0);
      chk("rst_ls", 32'(ls4), 0);
      chk("rst_cx", 32'(cx4), 0);
      chk("rst_cy", 32'(cy4), 0);
      rst = 1'b1;
      step(2);
      // clean press / release, 4-cycle debounce
      ml4 = 1'b1;
      step(5);
      chk("t1_click_early", 32'(click4), 0);
      chk("t1_ls_early", 32'(ls4), 0);
      step(1);
      chk("t1_click", 32'(click4), 1);
      chk("t1_cx", 32'(cx4), 300);
      chk("t1_cy", 32'(cy4), 200);
      chk("t1_ls", 32'(ls4), 1);
      step(1);
      chk("t1_click_drop", 32'(click4), 0);
      step(13);
      ml4 = 1'b0;
      step(5);
      chk("t1_rel_early", 32'(rel4), 0);
      chk("t1_ls_hold", 32'(ls4), 1);
      step(1);
      chk("t1_rel", 32'(rel4), 1);
      chk("t1_ls_low", 32'(ls4), 0);
      step(1);
      chk("t1_rel_drop", 32'(rel4), 0);
      chk("t1_nclick", 32'(n_click4), 1);
      // short glitches in both debounce states
      base_c = n_click4;
      ml4 = 1'b1;
      step(3);
      ml4 = 1'b0;
      step(2);
      chk("t2_ls_glitch", 32'(ls4), 0);
      step(8);
      chk("t2_no_click", 32'(n_click4 - base_c), 0);
      ml4 = 1'b1;
      step(8);
      chk("t2_press_click", 32'(n_click4 - base_c), 1);
      base_r = n_rel4;
      ml4 = 1'b0;
      step(3);
      ml4 = 1'b1;
      step(2);
      chk("t2_ls_relglitch", 32'(ls4), 1);
      step(8);
      chk("t2_no_release", 32'(n_rel4 - base_r), 0);
      chk("t2_ls_still", 32'(ls4), 1);
      ml4 = 1'b0;
      step(8);
      chk("t2_release", 32'(n_rel4 - base_r), 1);
      // enable rises while held: no click and no release for that press
      base_c = n_click4;
      base_r = n_rel4;
      enable = 1'b0;
      ml4 = 1'b1;
      step(8);
      chk("t3_ls", 32'(ls4), 1);
      enable = 1'b1;
      step(3);
      ml4 = 1'b0;
      step(8);
      chk("t3_ls_low", 32'(ls4), 0);
      chk("t3_no_click", 32'(n_click4 - base_c), 0);
      chk("t3_no_release", 32'(n_rel4 - base_r), 0);
      ml4 = 1'b1;
      step(6);
      chk("t3_next_click", 32'(click4), 1);
      step(2);
      ml4 = 1'b0;
      step(8);
      chk("t3_next_release", 32'(n_rel4 - base_r), 1);
      // clamping and motion after capture
      xpos = 12'd1500;
      ypos = 12'd900;
      ml4 = 1'b1;
      step(3);
      xpos = 12'd10;
      ypos = 12'd10;
      step(3);
      chk("t4_click", 32'(click4), 1);
      chk("t4_cx", 32'(cx4), 1023);
      chk("t4_cy", 32'(cy4), 767);
      ml4 = 1'b0;
      step(8);
      chk("t4_cx_held", 32'(cx4), 1023);
      xpos = 12'd300;
      ypos = 12'd200;
      // single-cycle debounce
      ml1 = 1'b1;
      step(2);
      chk("t5_click_early", 32'(click1), 0);
      step(1);
      chk("t5_click", 32'(click1), 1);
      chk("t5_cx", 32'(cx1), 300);
      chk("t5_ls", 32'(ls1), 1);
      step(1);
      chk("t5_click_drop", 32'(click1), 0);
      ml1 = 1'b0;
      step(5);
      base_c = n_click1;
      base_r = n_rel1;
      for (int i = 0; i < 8; i++) begin
         ml1 = ~ml1;
         step(2);
      end
      step(4);
      chk("t5_toggle_clicks", 32'(n_click1 - base_c), 4);
      chk("t5_toggle_releases", 32'(n_rel1 - base_r), 4);
      chk("t5_never_both", 32'(n_both), 0);
      // asynchronous reset mid-debounce and mid-pulse
      ml4 = 1'b1;
      step(4);
      rst = 1'b0;
      #1;
      chk("t6_db_click", 32'(click4), 0);
      chk("t6_db_ls", 32'(ls4), 0);
      chk("t6_db_cx", 32'(cx4), 0);
      chk("t6_db_cy", 32'(cy4), 0);
      rst = 1'b1;
      step(5);
      chk("t6_held_early", 32'(click4), 0);
      step(1);
      chk("t6_held_click", 32'(click4), 1);
      chk("t6_held_cx", 32'(cx4), 300);
      rst = 1'b0;
      #1;
      chk("t6_pulse_click", 32'(click4), 0);
      chk("t6_pulse_release", 32'(rel4), 0);
      chk("t6_pulse_ls", 32'(ls4), 0);
      chk("t6_pulse_cx", 32'(cx4), 0);
      chk("t6_pulse_cy", 32'(cy4), 0);
      rst = 1'b1;
      ml4 = 1'b0;
      step(10);
      chk("t6_quiet_release", 32'(rel4), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
